// File: rtl/map_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// map_pkg : shared map geometry, tile codes and controller state encoding
// Rev 1.0
// ----------------------------------------------------------------------
package map_pkg;

  localparam int MAP_W     = 21;
  localparam int MAP_H     = 21;
  localparam int MAP_CELLS = MAP_W * MAP_H;

  localparam logic [4:0] C_X_MAX    = 5'(MAP_W - 1);
  localparam logic [4:0] C_Y_MAX    = 5'(MAP_H - 1);
  localparam logic [8:0] C_LAST_IDX = 9'(MAP_CELLS - 1);
  localparam logic [8:0] C_ORB_MAX  = 9'(MAP_CELLS);

  localparam logic [2:0] TILE_BLACK     = 3'b000;
  localparam logic [2:0] TILE_BIG_ORB   = 3'b001;
  localparam logic [2:0] TILE_SMALL_ORB = 3'b010;
  localparam logic [2:0] TILE_WALL      = 3'b011;
  localparam logic [2:0] TILE_GATE      = 3'b100;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  function automatic logic is_orb(input logic [2:0] t);
    return (t == TILE_BIG_ORB) || (t == TILE_SMALL_ORB);
  endfunction

  function automatic logic [8:0] cell_idx(input logic [4:0] x, input logic [4:0] y);
    return ({4'b0, y} * 9'd21) + {4'b0, x};
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_layout_rom.sv
`default_nettype none
// ----------------------------------------------------------------------
// map_layout_rom : combinational default layout, cell index -> tile code
// Rev 1.0
// ----------------------------------------------------------------------
module map_layout_rom
  import map_pkg::*;
(
  input  logic [8:0] i_idx,
  output logic [2:0] o_tile
);

  logic [8:0] w_x;
  logic [4:0] w_y;

  always_comb begin
    // Row/column split by repeated subtraction keeps the ROM divider-free
    w_x = i_idx;
    w_y = '0;
    for (int r = 0; r < MAP_H; r++) begin
      if (w_x >= 9'(MAP_W)) begin
        w_x = w_x - 9'(MAP_W);
        w_y = w_y + 5'd1;
      end
    end

    if (w_x == 9'd0 || w_x == 9'(C_X_MAX) || w_y == 5'd0 || w_y == C_Y_MAX)
      o_tile = TILE_WALL;
    else if (w_x == 9'd10 && w_y == 5'd10)
      o_tile = TILE_BLACK;
    else if (w_x == 9'd10 && w_y == 5'd9)
      o_tile = TILE_GATE;
    else if ((w_x == 9'd1 || w_x == 9'd19) && (w_y == 5'd1 || w_y == 5'd19))
      o_tile = TILE_BIG_ORB;
    else if (!w_x[0] && !w_y[0])
      o_tile = TILE_WALL;
    else
      o_tile = TILE_SMALL_ORB;
  end

endmodule
`default_nettype wire

// File: rtl/map_controller.sv
`default_nettype none
// ----------------------------------------------------------------------
// map_controller : tile map RAM with default-layout load, writes, orb count
// Rev 1.0
// ----------------------------------------------------------------------
module map_controller
  import map_pkg::*;
(
  input  logic       clock_50,
  input  logic       resetn,
  input  logic       init,
  output logic       busy,
  input  logic [4:0] map_x,
  input  logic [4:0] map_y,
  output logic [2:0] sprite_type,
  input  logic       wr_en,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_type,
  output logic       wr_ack,
  output logic       wr_err,
  output logic [8:0] orbs_left,
  output logic       level_clear
);

  state_t     r_state, w_state_nxt;
  logic [8:0] r_cnt;
  logic [8:0] r_orbs, w_orbs_nxt;
  logic       r_level_clear, r_wr_ack, r_wr_err, w_err_nxt;
  logic       r_rd_valid, r_old_orb;
  logic [2:0] r_rd_data;

  logic [2:0] r_mem     [0:MAP_CELLS-1];
  logic       r_orb_mem [0:MAP_CELLS-1];

  logic       w_rd_ok, w_wr_ok, w_we;
  logic [8:0] w_rd_addr, w_wr_addr, w_waddr;
  logic [2:0] w_wdata, w_rom_tile;

  map_layout_rom u_rom (
    .i_idx  (r_cnt),
    .o_tile (w_rom_tile)
  );

  assign w_rd_ok   = (map_x <= C_X_MAX) && (map_y <= C_Y_MAX);
  assign w_wr_ok   = (wr_x <= C_X_MAX) && (wr_y <= C_Y_MAX) && (wr_type <= TILE_GATE);
  assign w_rd_addr = w_rd_ok ? cell_idx(map_x, map_y) : 9'd0;
  assign w_wr_addr = w_wr_ok ? cell_idx(wr_x, wr_y) : 9'd0;

  // Orb flags live in a parallel RAM so the old cell's orb status is known
  // in the WRITE cycle without a second read port on the tile RAM.
  always_ff @(posedge clock_50) begin
    if (w_we) begin
      r_mem[w_waddr]     <= w_wdata;
      r_orb_mem[w_waddr] <= is_orb(w_wdata);
    end
    r_rd_data <= r_mem[w_rd_addr];
    r_old_orb <= r_orb_mem[w_wr_addr];
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = w_wr_addr;
    w_wdata     = wr_type;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_cnt;
        w_wdata = w_rom_tile;
        if (r_cnt == C_LAST_IDX) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (init)         w_state_nxt = ST_INIT;
        else if (wr_en) begin
          if (w_wr_ok)    w_state_nxt = ST_WRITE;
          else            w_err_nxt   = 1'b1;
        end
      end
      ST_WRITE: begin
        w_we        = 1'b1;
        w_state_nxt = init ? ST_INIT : ST_READY;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_orbs_nxt = r_orbs;
    if (r_state == ST_INIT) begin
      w_orbs_nxt = (r_cnt == 9'd0) ? 9'd0 : r_orbs;
      if (is_orb(w_rom_tile)) w_orbs_nxt = w_orbs_nxt + 9'd1;
    end else if (r_state == ST_WRITE) begin
      if (r_old_orb && !is_orb(wr_type) && r_orbs != 9'd0)
        w_orbs_nxt = r_orbs - 9'd1;
      else if (!r_old_orb && is_orb(wr_type) && r_orbs != C_ORB_MAX)
        w_orbs_nxt = r_orbs + 9'd1;
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      r_cnt         <= '0;
      r_orbs        <= '0;
      r_level_clear <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_wr_err      <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      // Counter parks at 0 outside INIT so every entry starts at index 0
      r_cnt         <= (r_state == ST_INIT) ? r_cnt + 9'd1 : 9'd0;
      r_orbs        <= w_orbs_nxt;
      r_level_clear <= (w_orbs_nxt == 9'd0) && (w_state_nxt != ST_INIT);
      r_wr_ack      <= (r_state == ST_WRITE);
      r_wr_err      <= w_err_nxt;
      r_rd_valid    <= w_rd_ok && (r_state != ST_INIT);
    end
  end

  assign busy        = (r_state == ST_INIT);
  assign sprite_type = r_rd_valid ? r_rd_data : TILE_BLACK;
  assign wr_ack      = r_wr_ack;
  assign wr_err      = r_wr_err;
  assign orbs_left   = r_orbs;
  assign level_clear = r_level_clear;

endmodule
`default_nettype wire

// File: tb/tb_map_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------
// tb_map_controller : directed self-checking bench for map_controller
// Rev 1.0
// ----------------------------------------------------------------------
module tb_map_controller;

  logic       clock_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       init     = 1'b0;
  logic       busy;
  logic [4:0] map_x    = '0;
  logic [4:0] map_y    = '0;
  logic [2:0] sprite_type;
  logic       wr_en    = 1'b0;
  logic [4:0] wr_x     = '0;
  logic [4:0] wr_y     = '0;
  logic [2:0] wr_type  = '0;
  logic       wr_ack, wr_err;
  logic [8:0] orbs_left;
  logic       level_clear;

  map_controller dut (
    .clock_50    (clock_50),
    .resetn      (resetn),
    .init        (init),
    .busy        (busy),
    .map_x       (map_x),
    .map_y       (map_y),
    .sprite_type (sprite_type),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_type     (wr_type),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .orbs_left   (orbs_left),
    .level_clear (level_clear)
  );

  always #10 clock_50 = ~clock_50;

  int n_chk = 0;
  int n_err = 0;
  int mdl [0:20][0:20];

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Default layout: walled border, pillar grid on even/even, four big orbs,
  // gate at (10,9), empty cell at (10,10), small orbs elsewhere.
  function automatic int rom_tile(int x, int y);
    bit border = (x == 0) || (x == 20) || (y == 0) || (y == 20);
    bit corner = (x == 1 || x == 19) && (y == 1 || y == 19);
    if (border)                          return 3;
    if (x == 10 && y == 10)              return 0;
    if (x == 10 && y == 9)               return 4;
    if (corner)                          return 1;
    if ((x % 2) == 0 && (y % 2) == 0)    return 3;
    return 2;
  endfunction

  task automatic load_model();
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        mdl[y][x] = rom_tile(x, y);
  endtask

  function automatic int model_orbs();
    int n = 0;
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        if (mdl[y][x] == 1 || mdl[y][x] == 2) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic wait_load(output int cyc);
    cyc = 0;
    while (busy && cyc < 1000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic read_cell(input int x, input int y, output int v);
    @(negedge clock_50);
    map_x = 5'(x);
    map_y = 5'(y);
    tick();
    v = int'(sprite_type);
  endtask

  task automatic do_write(input int x, input int y, input int t,
                          output int lat, output logic ack, output logic err);
    @(negedge clock_50);
    wr_x = 5'(x); wr_y = 5'(y); wr_type = 3'(t); wr_en = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0;
    while (!ack && !err && lat < 10) begin
      tick();
      lat++;
      ack = wr_ack;
      err = wr_err;
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, v, lat, nw, nack;
    logic ack, err;

    repeat (3) @(posedge clock_50);
    #1;
    chk_eq("rst_busy",   busy,        1);
    chk_eq("rst_sprite", sprite_type, 0);
    chk_eq("rst_ack",    wr_ack,      0);
    chk_eq("rst_err",    wr_err,      0);
    chk_eq("rst_orbs",   orbs_left,   0);
    chk_eq("rst_lclr",   level_clear, 0);

    @(negedge clock_50) resetn = 1'b1;
    wait_load(cyc);
    load_model();
    chk_eq("load_cycles", cyc, 441);
    chk_eq("load_orbs",   orbs_left, model_orbs());
    chk_eq("load_lclr",   level_clear, 0);

    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++) begin
        read_cell(x, y, v);
        chk_eq($sformatf("rd_%0d_%0d", x, y), v, mdl[y][x]);
      end
    read_cell(21, 0, v);  chk_eq("rd_oob_x",  v, 0);
    read_cell(0, 21, v);  chk_eq("rd_oob_y",  v, 0);
    read_cell(31, 31, v); chk_eq("rd_oob_xy", v, 0);

    do_write(3, 1, 0, lat, ack, err);
    mdl[1][3] = 0;
    chk_eq("w31_ack",  ack, 1);
    chk_eq("w31_lat",  lat, 2);
    chk_eq("w31_orbs", orbs_left, model_orbs());
    read_cell(3, 1, v);
    chk_eq("w31_rd",   v, 0);

    // Read and write the same cell on the same edge
    @(negedge clock_50);
    map_x = 5'd5; map_y = 5'd1;
    wr_x = 5'd5; wr_y = 5'd1; wr_type = 3'd0; wr_en = 1'b1;
    tick();
    tick();
    chk_eq("raw_ack", wr_ack, 1);
    chk_eq("raw_old", sprite_type, 2);
    wr_en = 1'b0;
    mdl[1][5] = 0;
    tick();
    chk_eq("raw_new", sprite_type, 0);

    do_write(21, 1, 0, lat, ack, err);
    chk_eq("ex_err", err, 1);
    chk_eq("ex_ack", ack, 0);
    chk_eq("ex_lat", lat, 1);
    do_write(4, 1, 6, lat, ack, err);
    chk_eq("et_err", err, 1);
    chk_eq("et_lat", lat, 1);
    chk_eq("err_orbs", orbs_left, model_orbs());
    read_cell(4, 1, v);
    chk_eq("err_rd", v, 2);

    nw = 0; nack = 0;
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        if (mdl[y][x] == 1 || mdl[y][x] == 2) begin
          do_write(x, y, 0, lat, ack, err);
          nw++;
          if (ack) nack++;
          mdl[y][x] = 0;
        end
    chk_eq("clr_acks", nack, nw);
    chk_eq("clr_orbs", orbs_left, 0);
    chk_eq("clr_lclr", level_clear, 1);
    do_write(10, 10, 2, lat, ack, err);
    mdl[10][10] = 2;
    chk_eq("one_ack",  ack, 1);
    chk_eq("one_orbs", orbs_left, 1);
    chk_eq("one_lclr", level_clear, 0);

    // init raised during the WRITE cycle and held into the reload
    @(negedge clock_50);
    wr_x = 5'd3; wr_y = 5'd1; wr_type = 3'd2; wr_en = 1'b1;
    tick();
    init = 1'b1;
    tick();
    chk_eq("iw_ack",  wr_ack, 1);
    chk_eq("iw_busy", busy,   1);
    wr_en = 1'b0;
    cyc = 0;
    while (busy && cyc < 1000) begin
      tick();
      cyc++;
      if (cyc == 100) init = 1'b0;
    end
    load_model();
    chk_eq("iw_cycles", cyc, 441);
    chk_eq("iw_orbs",   orbs_left, model_orbs());
    chk_eq("iw_lclr",   level_clear, 0);
    read_cell(3, 1, v);   chk_eq("iw_rd31",   v, 2);
    read_cell(10, 10, v); chk_eq("iw_rd1010", v, 0);
    read_cell(5, 1, v);   chk_eq("iw_rd51",   v, 2);

    // Reset pulsed partway through a reload
    @(negedge clock_50);
    map_x = 5'd3; map_y = 5'd1;
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (200) tick();
    chk_eq("mid_busy_rd", sprite_type, 0);
    @(negedge clock_50) resetn = 1'b0;
    #1;
    chk_eq("mid_busy", busy,        1);
    chk_eq("mid_orbs", orbs_left,   0);
    chk_eq("mid_lclr", level_clear, 0);
    chk_eq("mid_spr",  sprite_type, 0);
    chk_eq("mid_ack",  wr_ack,      0);
    chk_eq("mid_err",  wr_err,      0);
    @(negedge clock_50) resetn = 1'b1;
    wait_load(cyc);
    chk_eq("mid_cycles", cyc, 441);
    chk_eq("mid_orbs2",  orbs_left, model_orbs());
    read_cell(1, 1, v);   chk_eq("mid_rd11",  v, 1);
    read_cell(10, 9, v);  chk_eq("mid_rd109", v, 4);
    read_cell(20, 20, v); chk_eq("mid_rd2020", v, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_controller.md
MAP_CONTROLLER -- requirements
Module: map_controller

Interface
REQ-001 clock_50  in  1  system clock; all state on rising edge.
REQ-002 resetn  in  1  reset, asynchronous assert, active-low; synchronous release to clock_50.
REQ-003 init  in  1  level-sensitive request to reload the default layout.
REQ-004 busy  out  1  high while layout load (INIT) in progress.
REQ-005 map_x  in  5  read column, 0..20.
REQ-006 map_y  in  5  read row, 0..20.
REQ-007 sprite_type  out  3  tile code at (map_x, map_y), registered.
REQ-008 wr_en  in  1  write request; held with data until wr_ack or wr_err.
REQ-009 wr_x  in  5  write column.
REQ-010 wr_y  in  5  write row.
REQ-011 wr_type  in  3  new tile code.
REQ-012 wr_ack  out  1  one-cycle pulse: write committed.
REQ-013 wr_err  out  1  one-cycle pulse: write rejected, map unchanged.
REQ-014 orbs_left  out  9  count of cells holding code 001 or 010.
REQ-015 level_clear  out  1  high when orbs_left==0 and not busy.

Function
REQ-016 Storage: 441 cells x 3 bits, cell index = y*21 + x (9-bit).
REQ-017 Tile codes: 000 black, 001 big orb, 010 small orb, 011 blue wall, 100 grey gate; 101-111 invalid.
REQ-018 Read latency: exactly 1 cycle; sprite_type reflects the map_x/map_y sampled on the previous edge.
REQ-019 Read with map_x>20 or map_y>20, or any read while busy: sprite_type = 000.
REQ-020 FSM states: INIT, READY, WRITE.
REQ-021 INIT: 9-bit counter 0..440, one cell per cycle copied from layout ROM; orb counter rebuilt from zero; after index 440, next state READY; total 441 cycles with busy=1.
REQ-022 READY: init=1 -> INIT (priority over wr_en); else wr_en=1 with valid request -> WRITE; else wr_en=1 with wr_x>20, wr_y>20 or wr_type>100 -> wr_err pulse next cycle, stay READY.
REQ-023 WRITE (1 cycle): old cell value read, new value written, orbs_left updated, wr_ack pulsed; next state READY (or INIT if init=1).
REQ-024 Orb update: old orb -> new non-orb decrements by 1; old non-orb -> new orb increments by 1; orb->orb or non->non unchanged; never wraps below 0 or above 441.
REQ-025 Requester must drop wr_en in the cycle after wr_ack/wr_err; a still-high wr_en in READY is a new request.
REQ-026 wr_en during INIT or WRITE: not sampled, no ack/err.
REQ-027 Read and write same cell in same cycle: read returns old value; new value visible from the following read.
REQ-028 init asserted during WRITE: write completes and acks first, then INIT.
REQ-029 init held high during INIT: no restart; INIT re-entered only if still high on return to READY.
REQ-030 level_clear registered, updated same edge as orbs_left.

Reset
REQ-031 resetn low: state INIT, counter 0, sprite_type 000, busy 1, wr_ack 0, wr_err 0, orbs_left 0, level_clear 0.
REQ-032 Cell RAM not reset; contents defined only after INIT completes.
REQ-033 resetn low mid-INIT or mid-WRITE: abandon operation, restart INIT at index 0 after release.

Structure
REQ-034 Shared package map_pkg: tile codes, MAP_W=21, MAP_H=21, MAP_CELLS=441, FSM state encoding.
REQ-035 Sub-module map_layout_rom: combinational 9-bit index -> 3-bit default tile code.
REQ-036 Cell RAM single write port, single read port, inferable as block RAM.

Verification
REQ-037 Release resetn -> busy=1 for 441 cycles then 0; orbs_left equals ROM-model orb count; reads of all 441 cells match ROM.
REQ-038 Write (3,1)=000 over small orb -> wr_ack 2 cycles after wr_en edge, orbs_left-1, read (3,1) returns 000.
REQ-039 Write wr_x=21, then wr_type=110 -> wr_err pulse each, no map or count change.
REQ-040 Clear every orb -> level_clear=1; write 010 to any black cell -> orbs_left=1, level_clear=0.
REQ-041 init raised in WRITE cycle -> wr_ack, then busy 441 cycles, layout and count restored.
REQ-042 resetn pulsed at INIT index 200 -> outputs at reset values, INIT restarts at 0, full 441-cycle load.
